// File: rtl/seg7_scan.sv
// Two-digit multiplexed common-anode 7-segment scanner with blank slots and per-frame digit snapshot.
// Optional blink feature enabled by defining BLINK_EN.
module seg7_scan #(
   parameter int unsigned DRIVE_CYC    = 50000,
   parameter int unsigned BLANK_CYC    = 500,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] q_tens,
   input  logic [3:0] q_units,
`ifdef BLINK_EN
   input  logic       blink,
`endif
   output logic [1:0] an,
   output logic [6:0] seg
);

   localparam int unsigned MAX_CYC = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
   localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CW-1:0] DRV_LAST = CW'(DRIVE_CYC - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {BLANK_U, DRIVE_U, BLANK_T, DRIVE_T} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            first_q;
   logic [3:0]      snap_t_q, snap_u_q;
   logic [1:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            last;
   logic            load;
   logic            vis;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

`ifdef BLINK_EN
   localparam int unsigned FW = $clog2(2 * BLINK_FRAMES);
   logic [FW-1:0] frame_q;
   logic          dark_q;

   // Darkness is decided once per frame from the pre-increment frame count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_q <= '0;
         dark_q  <= 1'b0;
      end else if (load) begin
         dark_q  <= blink && (frame_q >= FW'(BLINK_FRAMES));
         frame_q <= (frame_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end
   end

   assign vis = ~dark_q;
`else
   assign vis = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      an_d    = 2'b11;
      seg_d   = 7'h7F;
      last    = (state_q == DRIVE_U || state_q == DRIVE_T) ? (cnt_q == DRV_LAST)
                                                           : (cnt_q == BLK_LAST);
      if (last) begin
         cnt_d = '0;
         case (state_q)
            BLANK_U: state_d = DRIVE_U;
            DRIVE_U: state_d = BLANK_T;
            BLANK_T: state_d = DRIVE_T;
            default: state_d = BLANK_U;
         endcase
      end
      // The first edge after reset counts as a BLANK_U entry for snapshotting.
      load = first_q | (state_q == DRIVE_T && last);
      if (vis) begin
         case (state_d)
            DRIVE_U: begin
               an_d  = 2'b10;
               seg_d = decode(snap_u_q);
            end
            DRIVE_T: begin
               an_d  = 2'b01;
               seg_d = decode(snap_t_q);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= BLANK_U;
         cnt_q    <= '0;
         first_q  <= 1'b1;
         snap_t_q <= '0;
         snap_u_q <= '0;
         an_q     <= 2'b11;
         seg_q    <= 7'h7F;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= 1'b0;
         an_q    <= an_d;
         seg_q   <= seg_d;
         if (load) begin
            snap_t_q <= q_tens;
            snap_u_q <= q_units;
         end
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: frame-position reference model plus directed literal checks.
// Define BLINK_EN to also exercise the blink feature.
module tb_seg7_scan;

   localparam int unsigned DRV = 4;
   localparam int unsigned BLK = 2;
   localparam int unsigned FRAME = 2 * (DRV + BLK);

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] q_tens = 4'd5;
   logic [3:0] q_units = 4'd9;
   logic       blink = 1'b0;
   logic [1:0] an;
   logic [6:0] seg;

   int checks = 0;
   int passes = 0;

   seg7_scan #(.DRIVE_CYC(DRV), .BLANK_CYC(BLK), .BLINK_FRAMES(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .q_tens  (q_tens),
      .q_units (q_units),
`ifdef BLINK_EN
      .blink   (blink),
`endif
      .an      (an),
      .seg     (seg)
   );

   always #5 clk = ~clk;

   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   // Model: k = clock edges since reset release; snapshot on edge 1 and every frame boundary.
   int         k = 0;
   int         loads_m = 0;
   logic [3:0] snap_t_m = '0;
   logic [3:0] snap_u_m = '0;
   logic       dark_m = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         k       <= 0;
         loads_m <= 0;
         dark_m  <= 1'b0;
      end else begin
         k <= k + 1;
         if (k + 1 == 1 || (k + 1) % FRAME == 0) begin
            snap_t_m <= q_tens;
            snap_u_m <= q_units;
            dark_m   <= blink && (loads_m % 4 >= 2);
            loads_m  <= loads_m + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s at %0t (k=%0d): got %h expected %h", nm, $time, k, act, exp);
      else
         passes++;
   endtask

   int         pos;
   logic [8:0] exp_m;

   always @(negedge clk) begin
      if (!reset) begin
         chk("reset_blank", {an, seg}, {2'b11, 7'h7F});
      end else begin
         pos = k % FRAME;
         if (pos >= BLK && pos < BLK + DRV && !dark_m)
            exp_m = {2'b10, tbl[snap_u_m]};
         else if (pos >= 2 * BLK + DRV && !dark_m)
            exp_m = {2'b01, tbl[snap_t_m]};
         else
            exp_m = {2'b11, 7'h7F};
         chk("scan", {an, seg}, exp_m);
         chk("one_anode", {8'd0, an == 2'b00}, 9'd0);
      end
   end

   task automatic wait_pos(input int p);
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (reset && k % FRAME == p) return;
      end
      checks++;
      $display("FAIL wait_pos timeout: got no position %0d expected within %0d cycles", p, 3 * FRAME);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      reset = 1'b1;
      wait_pos(1);  chk("t1_blank_after_release", {an, seg}, {2'b11, 7'h7F});
      wait_pos(2);  chk("t2_units_59",            {an, seg}, {2'b10, 7'h10});
      wait_pos(9);  chk("t2_tens_59",             {an, seg}, {2'b01, 7'h12});
      wait_pos(2);  chk("t1_period",              {an, seg}, {2'b10, 7'h10});
      wait_pos(9);  q_tens = 4'd3; q_units = 4'd7;
      wait_pos(3);  chk("t3_units_37",            {an, seg}, {2'b10, 7'h78});
      q_tens = 4'd4; q_units = 4'd0;
      wait_pos(9);  chk("t3_tens_torn_guard",     {an, seg}, {2'b01, 7'h30});
      wait_pos(3);  chk("t3_units_next",          {an, seg}, {2'b10, 7'h40});
      wait_pos(9);  chk("t3_tens_next",           {an, seg}, {2'b01, 7'h19});
      q_tens = 4'hF; q_units = 4'hB;
      wait_pos(3);  chk("t4_units_dash",          {an, seg}, {2'b10, 7'h3F});
      wait_pos(9);  chk("t4_tens_dash",           {an, seg}, {2'b01, 7'h3F});
      #1 reset = 1'b0;
      #1 chk("t5_async_reset", {an, seg}, {2'b11, 7'h7F});
      repeat (2) @(negedge clk);
      q_tens = 4'd2; q_units = 4'd1;
      reset = 1'b1;
      wait_pos(3);  chk("t5_fresh_units", {an, seg}, {2'b10, 7'h79});
      wait_pos(9);  chk("t5_fresh_tens",  {an, seg}, {2'b01, 7'h24});
      q_tens = 4'd7;
      wait_pos(9);  chk("tens_no_clamp",  {an, seg}, {2'b01, 7'h78});
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) q_units = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) q_tens  = 4'($urandom_range(0, 15));
      end
`ifdef BLINK_EN
      blink = 1'b1;
      repeat (10 * FRAME) @(negedge clk);
      blink = 1'b0;
      repeat (3 * FRAME) @(negedge clk);
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
